// File: rtl/bus_arbiter_pkg.sv
// Shared types for the fetch/execute bus arbiter: FSM states, owner
// encoding, the latched bus request and the fetch request builder.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic {
        OWNER_FETCH,
        OWNER_EXEC
    } arb_owner_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [3:0]  strobe;
    } bus_request_t;

    // Fetch only ever reads whole words.
    localparam logic [3:0] FETCH_STROBE = 4'hF;

    // Fetch carries only an address; the rest of the request is fixed.
    function automatic bus_request_t fetch_request(input logic [31:0] addr);
        bus_request_t r;
        r.addr   = addr;
        r.wdata  = 32'h0;
        r.write  = 1'b0;
        r.strobe = FETCH_STROBE;
        return r;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the arbiter, its two requesters and the bus.
// The arbiter takes the slave view; requesters and the bus model take
// the master view.
interface bus_arbiter_if;

    logic        f_req_valid;
    logic        f_req_ready;
    logic [31:0] f_addr;
    logic        f_resp_valid;
    logic [31:0] f_rdata;
    logic        f_error;

    logic        e_req_valid;
    logic        e_req_ready;
    logic [31:0] e_addr;
    logic        e_write;
    logic [31:0] e_wdata;
    logic [3:0]  e_strobe;
    logic        e_resp_valid;
    logic [31:0] e_rdata;
    logic        e_error;

    logic        m_req_valid;
    logic        m_req_ready;
    logic [31:0] m_addr;
    logic        m_write;
    logic [31:0] m_wdata;
    logic [3:0]  m_strobe;
    logic        m_resp_valid;
    logic [31:0] m_rdata;
    logic        m_error;

    modport slave (
        input  f_req_valid, f_addr,
        output f_req_ready, f_resp_valid, f_rdata, f_error,
        input  e_req_valid, e_addr, e_write, e_wdata, e_strobe,
        output e_req_ready, e_resp_valid, e_rdata, e_error,
        output m_req_valid, m_addr, m_write, m_wdata, m_strobe,
        input  m_req_ready, m_resp_valid, m_rdata, m_error
    );

    modport master (
        output f_req_valid, f_addr,
        input  f_req_ready, f_resp_valid, f_rdata, f_error,
        output e_req_valid, e_addr, e_write, e_wdata, e_strobe,
        input  e_req_ready, e_resp_valid, e_rdata, e_error,
        input  m_req_valid, m_addr, m_write, m_wdata, m_strobe,
        output m_req_ready, m_resp_valid, m_rdata, m_error
    );

endinterface

// File: rtl/bus_arbiter_picker.sv
// Execute-priority grant selection with a saturating starvation counter
// that hands one contested arbitration to fetch after STARVE_LIMIT losses.
module arb_priority_picker
    import bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic arbitrate,
    input  logic fetch_valid,
    input  logic exec_valid,
    output logic grant_fetch,
    output logic grant_exec
);

    logic [3:0] starve_cnt;
    logic       fetch_due;

    assign fetch_due = (starve_cnt == 4'(STARVE_LIMIT));

    // Fetch wins when alone or when it has lost often enough.
    always_comb begin
        grant_fetch = arbitrate && fetch_valid && (!exec_valid || fetch_due);
        grant_exec  = arbitrate && exec_valid && !grant_fetch;
    end

    // Count arbitrations fetch took part in and lost; clear on a fetch win.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (arbitrate && fetch_valid) begin
            if (grant_fetch) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one bus master port between fetch and execute: one transaction
// at a time, grant held until the response (or a watchdog timeout) and
// the response routed back to the owner.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clock,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    arb_state_t   state;
    arb_state_t   state_next;
    arb_owner_t   owner;
    bus_request_t req_q;
    logic [15:0]  timeout_cnt;

    logic arbitrate;
    logic grant_fetch;
    logic grant_exec;
    logic resp_fire;
    logic timeout_hit;
    logic done;
    logic owner_fetch;
    logic owner_exec;

    // Readies are held low while reset is asserted, even with requests pending.
    assign arbitrate   = (state == ARB_IDLE) && reset;
    assign resp_fire   = (state == ARB_WAIT) && bus.m_resp_valid;
    // Fires on the TIMEOUT_CYCLES-th cycle spent in REQ+WAIT.
    assign timeout_hit = (state != ARB_IDLE) && (timeout_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign done        = resp_fire || timeout_hit;
    assign owner_fetch = (owner == OWNER_FETCH);
    assign owner_exec  = (owner == OWNER_EXEC);

    arb_priority_picker #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_picker (
        .clock       (clock),
        .reset       (reset),
        .arbitrate   (arbitrate),
        .fetch_valid (bus.f_req_valid),
        .exec_valid  (bus.e_req_valid),
        .grant_fetch (grant_fetch),
        .grant_exec  (grant_exec)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            ARB_IDLE: begin
                if (grant_fetch || grant_exec) begin
                    state_next = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (timeout_hit) begin
                    state_next = ARB_IDLE;
                end else if (bus.m_req_ready) begin
                    state_next = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (done) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Latch the winning request and owner; run the watchdog while busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_q       <= '0;
            owner       <= OWNER_FETCH;
            timeout_cnt <= 16'd0;
        end else if (grant_fetch) begin
            req_q       <= fetch_request(bus.f_addr);
            owner       <= OWNER_FETCH;
            timeout_cnt <= 16'd0;
        end else if (grant_exec) begin
            req_q.addr   <= bus.e_addr;
            req_q.wdata  <= bus.e_wdata;
            req_q.write  <= bus.e_write;
            req_q.strobe <= bus.e_strobe;
            owner        <= OWNER_EXEC;
            timeout_cnt  <= 16'd0;
        end else if (state != ARB_IDLE) begin
            timeout_cnt <= timeout_cnt + 16'd1;
        end
    end

    // Handshakes, bus request and response routing; a real response beats
    // a simultaneous timeout.
    always_comb begin
        bus.f_req_ready  = grant_fetch;
        bus.e_req_ready  = grant_exec;

        bus.m_req_valid  = (state == ARB_REQ) && !timeout_hit;
        bus.m_addr       = req_q.addr;
        bus.m_write      = req_q.write;
        bus.m_wdata      = req_q.wdata;
        bus.m_strobe     = req_q.strobe;

        bus.f_resp_valid = done && owner_fetch;
        bus.f_rdata      = (resp_fire && owner_fetch) ? bus.m_rdata : 32'h0;
        bus.f_error      = done && owner_fetch && (resp_fire ? bus.m_error : 1'b1);

        bus.e_resp_valid = done && owner_exec;
        bus.e_rdata      = (resp_fire && owner_exec) ? bus.m_rdata : 32'h0;
        bus.e_error      = done && owner_exec && (resp_fire ? bus.m_error : 1'b1);
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed transactions with a
// response scoreboard plus direct checks of handshakes and bus fields.
module tb_bus_arbiter;

    logic clock;
    logic reset;

    bus_arbiter_if ifc ();

    bus_arbiter #(
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    typedef struct {
        bit          fetch;
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input bit fetch, input logic [31:0] rdata, input logic error);
        exp_t e;
        e.fetch = fetch;
        e.rdata = rdata;
        e.error = error;
        sb.push_back(e);
    endtask

    // Response monitor: every response must match the oldest expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (ifc.f_resp_valid || ifc.e_resp_valid) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", {30'd0, ifc.f_resp_valid, ifc.e_resp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_owner", {30'd0, ifc.f_resp_valid, ifc.e_resp_valid},
                      e.fetch ? 32'd2 : 32'd1);
                check("resp_rdata", e.fetch ? ifc.f_rdata : ifc.e_rdata, e.rdata);
                check("resp_error", {31'd0, e.fetch ? ifc.f_error : ifc.e_error}, {31'd0, e.error});
                check("other_rdata", e.fetch ? ifc.e_rdata : ifc.f_rdata, 32'd0);
            end
        end
    end

    // Arbitration happens in the IDLE cycle the task is called in.
    task automatic arbitrate(input bit exp_fetch, input string tag);
        @(negedge clock);
        check({tag, "_f_ready"}, {31'd0, ifc.f_req_ready}, {31'd0, exp_fetch});
        check({tag, "_e_ready"}, {31'd0, ifc.e_req_ready}, {31'd0, !exp_fetch});
        tick;
    endtask

    // Bus side of a transaction, starting in the first REQ cycle.
    task automatic bus_phase(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                             input logic [3:0] st, input logic [31:0] rd, input logic er,
                             input int wait_cyc);
        @(negedge clock);
        check("m_req_valid", {31'd0, ifc.m_req_valid}, 32'd1);
        check("m_addr", ifc.m_addr, addr);
        check("m_write", {31'd0, ifc.m_write}, {31'd0, wr});
        check("m_wdata", ifc.m_wdata, wd);
        check("m_strobe", {28'd0, ifc.m_strobe}, {28'd0, st});
        check("req_ready_busy", {30'd0, ifc.f_req_ready, ifc.e_req_ready}, 32'd0);
        ifc.m_req_ready = 1'b1;
        tick;
        ifc.m_req_ready = 1'b0;
        for (int i = 0; i < wait_cyc; i++) begin
            @(negedge clock);
            check("wait_m_req_valid", {31'd0, ifc.m_req_valid}, 32'd0);
            tick;
        end
        ifc.m_resp_valid = 1'b1;
        ifc.m_rdata      = rd;
        ifc.m_error      = er;
        tick;
        ifc.m_resp_valid = 1'b0;
        ifc.m_rdata      = 32'h0;
        ifc.m_error      = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        reset            = 1'b0;
        ifc.f_req_valid  = 1'b1;
        ifc.f_addr       = 32'h0;
        ifc.e_req_valid  = 1'b1;
        ifc.e_addr       = 32'h0;
        ifc.e_write      = 1'b0;
        ifc.e_wdata      = 32'h0;
        ifc.e_strobe     = 4'h0;
        ifc.m_req_ready  = 1'b0;
        ifc.m_resp_valid = 1'b0;
        ifc.m_rdata      = 32'h0;
        ifc.m_error      = 1'b0;

        // Reset state: nothing granted even with both requesting.
        repeat (3) tick;
        @(negedge clock);
        check("rst_ready", {30'd0, ifc.f_req_ready, ifc.e_req_ready}, 32'd0);
        check("rst_m_req_valid", {31'd0, ifc.m_req_valid}, 32'd0);
        check("rst_m_addr", ifc.m_addr, 32'd0);
        check("rst_m_strobe", {28'd0, ifc.m_strobe}, 32'd0);
        check("rst_resp", {30'd0, ifc.f_resp_valid, ifc.e_resp_valid}, 32'd0);
        ifc.f_req_valid = 1'b0;
        ifc.e_req_valid = 1'b0;
        tick;
        reset = 1'b1;
        tick;

        // Fetch-only read.
        ifc.f_req_valid = 1'b1;
        ifc.f_addr      = 32'h100;
        arbitrate(1'b1, "fetch_only");
        ifc.f_req_valid = 1'b0;
        push_exp(1'b1, 32'h13, 1'b0);
        bus_phase(32'h100, 1'b0, 32'h0, 4'hF, 32'h13, 1'b0, 1);

        // Contention: execute store wins, fetch follows in the next IDLE.
        ifc.f_req_valid = 1'b1;
        ifc.f_addr      = 32'h300;
        ifc.e_req_valid = 1'b1;
        ifc.e_addr      = 32'h200;
        ifc.e_write     = 1'b1;
        ifc.e_wdata     = 32'hDEADBEEF;
        ifc.e_strobe    = 4'h3;
        arbitrate(1'b0, "contend_exec");
        ifc.e_req_valid = 1'b0;
        push_exp(1'b0, 32'h0, 1'b0);
        bus_phase(32'h200, 1'b1, 32'hDEADBEEF, 4'h3, 32'h0, 1'b0, 1);
        arbitrate(1'b1, "contend_fetch");
        ifc.f_req_valid = 1'b0;
        push_exp(1'b1, 32'hABCD, 1'b0);
        bus_phase(32'h300, 1'b0, 32'h0, 4'hF, 32'hABCD, 1'b0, 0);

        // Starvation: execute held valid; fetch takes arbitration #5 only.
        ifc.f_req_valid = 1'b1;
        ifc.f_addr      = 32'h600;
        ifc.e_req_valid = 1'b1;
        ifc.e_addr      = 32'h500;
        ifc.e_write     = 1'b1;
        ifc.e_wdata     = 32'hCAFEF00D;
        ifc.e_strobe    = 4'hC;
        for (int k = 1; k <= 6; k++) begin
            arbitrate(k == 5, $sformatf("starve%0d", k));
            push_exp(k == 5, 32'h11 * k, 1'b0);
            if (k == 5) begin
                bus_phase(32'h600, 1'b0, 32'h0, 4'hF, 32'h11 * k, 1'b0, 0);
            end else begin
                bus_phase(32'h500, 1'b1, 32'hCAFEF00D, 4'hC, 32'h11 * k, 1'b0, 0);
            end
        end
        ifc.f_req_valid = 1'b0;
        ifc.e_req_valid = 1'b0;
        tick;

        // Bus error on a fetch: error reported for exactly one cycle.
        ifc.f_req_valid = 1'b1;
        ifc.f_addr      = 32'h900;
        arbitrate(1'b1, "buserr");
        ifc.f_req_valid = 1'b0;
        push_exp(1'b1, 32'h55, 1'b1);
        bus_phase(32'h900, 1'b0, 32'h0, 4'hF, 32'h55, 1'b1, 2);
        @(negedge clock);
        check("buserr_one_cycle", {30'd0, ifc.f_resp_valid, ifc.f_error}, 32'd0);
        tick;

        // Timeout: bus accepts but never responds.
        ifc.e_req_valid = 1'b1;
        ifc.e_addr      = 32'h400;
        ifc.e_write     = 1'b0;
        ifc.e_wdata     = 32'h0;
        ifc.e_strobe    = 4'hF;
        arbitrate(1'b0, "timeout");
        ifc.e_req_valid = 1'b0;
        push_exp(1'b0, 32'h0, 1'b1);
        ifc.m_req_ready = 1'b1;
        @(negedge clock);
        check("to_m_req_valid", {31'd0, ifc.m_req_valid}, 32'd1);
        tick;
        ifc.m_req_ready = 1'b0;
        for (int i = 2; i <= 7; i++) begin
            @(negedge clock);
            check($sformatf("to_early%0d", i), {31'd0, ifc.e_resp_valid}, 32'd0);
            tick;
        end
        @(negedge clock);
        check("to_fire", {31'd0, ifc.e_resp_valid}, 32'd1);
        check("to_error", {31'd0, ifc.e_error}, 32'd1);
        tick;
        ifc.m_resp_valid = 1'b1;
        ifc.m_rdata      = 32'hBAD0BAD0;
        ifc.m_error      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("stray_resp", {30'd0, ifc.f_resp_valid, ifc.e_resp_valid}, 32'd0);
            check("stray_m_req_valid", {31'd0, ifc.m_req_valid}, 32'd0);
            tick;
        end
        ifc.m_resp_valid = 1'b0;
        ifc.m_rdata      = 32'h0;
        ifc.m_error      = 1'b0;

        // Reset while waiting for a response.
        ifc.f_req_valid = 1'b1;
        ifc.f_addr      = 32'h700;
        arbitrate(1'b1, "rstwait");
        ifc.m_req_ready = 1'b1;
        tick;
        ifc.m_req_ready = 1'b0;
        #2;
        reset = 1'b0;
        ifc.m_resp_valid = 1'b1;
        ifc.m_rdata      = 32'h99;
        #1;
        check("rstwait_m_req_valid", {31'd0, ifc.m_req_valid}, 32'd0);
        check("rstwait_m_addr", ifc.m_addr, 32'd0);
        check("rstwait_resp", {30'd0, ifc.f_resp_valid, ifc.e_resp_valid}, 32'd0);
        check("rstwait_ready", {30'd0, ifc.f_req_ready, ifc.e_req_ready}, 32'd0);
        ifc.f_req_valid = 1'b0;
        tick;
        reset = 1'b1;
        @(negedge clock);
        check("rstwait_pending_resp", {30'd0, ifc.f_resp_valid, ifc.e_resp_valid}, 32'd0);
        tick;
        ifc.m_resp_valid = 1'b0;
        ifc.m_rdata      = 32'h0;
        ifc.f_req_valid  = 1'b1;
        ifc.f_addr       = 32'h800;
        arbitrate(1'b1, "after_rst");
        ifc.f_req_valid = 1'b0;
        push_exp(1'b1, 32'h1234_5678, 1'b0);
        bus_phase(32'h800, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 1);
        repeat (2) tick;

        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single bus master port between the fetch stage (instruction reads) and the execute stage (loads/stores).
- Sits in the control unit between the Fetch/Execute blocks and the outgoing bus master.
- Grants one transaction at a time with execute priority and anti-starvation for fetch.
- Holds the grant until the response returns, then routes the response back to the owner. A watchdog ends hung transactions.

Parameters:
- STARVE_LIMIT, 4, consecutive arbitration losses by fetch after which fetch wins the next contested arbitration (1..15).
- TIMEOUT_CYCLES, 255, cycles in REQ+WAIT before a synthetic error response (1..65535).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- f_req_valid  in  1  fetch request valid (read-only)
- f_req_ready  out  1  fetch request accepted this cycle
- f_addr  in  32  fetch address
- f_resp_valid  out  1  fetch response valid (1 cycle)
- f_rdata  out  32  fetch read data
- f_error  out  1  fetch response error
- e_req_valid  in  1  execute request valid
- e_req_ready  out  1  execute request accepted
- e_addr  in  32  execute address
- e_write  in  1  1=store, 0=load
- e_wdata  in  32  store data
- e_strobe  in  4  byte strobes
- e_resp_valid  out  1  execute response valid (1 cycle)
- e_rdata  out  32  execute read data
- e_error  out  1  execute response error
- m_req_valid  out  1  bus request valid
- m_req_ready  in  1  bus accepts request
- m_addr  out  32  bus address
- m_write  out  1  bus write
- m_wdata  out  32  bus write data
- m_strobe  out  4  bus strobes
- m_resp_valid  in  1  bus response valid
- m_rdata  in  32  bus read data
- m_error  in  1  bus error

Behaviour:
- Reset (asynchronous, active-low):
  - State IDLE; all outputs 0; latched request cleared; starve and timeout counters 0.
  - Reset mid-transaction discards it; no response is issued to either requester.
- States: IDLE, REQ, WAIT. The owner register (FETCH/EXEC) is valid in REQ and WAIT.
- IDLE arbitration:
  - Only e_req_valid → EXEC.
  - Only f_req_valid → FETCH.
  - Both valid → EXEC, unless starve_cnt == STARVE_LIMIT, then FETCH.
  - Winner's *_req_ready = 1 combinationally in the same cycle. The loser's ready stays 0. Requesters must hold request fields stable until ready.
- Acceptance edge:
  - Latch the request: fetch forces write=0, wdata=0, strobe=4'hF.
  - Set owner; enter REQ; timeout counter = 0.
- Starve counter:
  - Increments when fetch was valid but lost; saturates at 15.
  - Clears when fetch wins.
  - Unchanged when fetch was not valid.
- REQ:
  - m_req_valid = 1 with latched fields; all *_req_ready = 0.
  - On m_req_ready → WAIT next edge.
  - Minimum latency: accept at cycle N, m_req_valid at N+1.
- WAIT:
  - m_req_valid = 0.
  - On m_resp_valid: owner's resp_valid = 1 combinationally, rdata = m_rdata, error = m_error; next state IDLE.
  - The non-owner's resp_valid stays 0 and its rdata stays 0.
- Back-to-back: a new request is accepted only in IDLE, so there is a minimum of 1 idle cycle between transactions.
- Timeout:
  - Counter increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES without completion, the owner gets resp_valid = 1, error = 1, rdata = 0; m_req_valid drops; return to IDLE.
- Stray responses: m_resp_valid in IDLE or REQ is ignored, with no output effect.
- A response in the same cycle the timeout fires takes precedence: real data, error = m_error.
- Widths: all data/address paths are 32-bit pass-through with no arithmetic. Counters are 4-bit (starve) and 16-bit (timeout).

Decomposition:
- Package bus_arbiter_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_REQ, ARB_WAIT}
  - arb_owner_t enum {OWNER_FETCH, OWNER_EXEC}
  - bus_request_t struct {addr[31:0], wdata[31:0], write, strobe[3:0]}
- Sub-module arb_priority_picker:
  - Holds the starve counter.
  - Inputs: the two valids plus an arbitrate strobe (state == IDLE).
  - Outputs: grant_fetch and grant_exec.
- The top holds the FSM, latch, timeout and response routing.

Test Plan:
- Fetch-only read:
  - Stimulus: f_req_valid, addr 0x100; m_req_ready 1 cycle later; m_resp_valid rdata 0x00000013 two cycles after that.
  - Required: f_req_ready at N; m_req_valid at N+1 with m_write=0, m_strobe=F; f_resp_valid=1, f_rdata=0x13; e_resp_valid stays 0.
- Contention:
  - Stimulus: both valid, store addr 0x200, wdata 0xDEADBEEF, strobe 0x3.
  - Required: EXEC granted; m_wdata=0xDEADBEEF, m_strobe=3; fetch serviced in the next IDLE.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: execute held continuously valid.
  - Required: fetch wins arbitration #5; starve_cnt clears; execute wins #6.
- Timeout, TIMEOUT_CYCLES=8:
  - Stimulus: m_req_ready is asserted, but m_resp_valid never comes.
  - Required: 8 cycles after acceptance, e_resp_valid=1, e_error=1, e_rdata=0; state IDLE; a later stray m_resp_valid produces no output.
- Bus error:
  - Stimulus: m_error=1 on a fetch response.
  - Required: f_error=1, f_resp_valid=1 for exactly one cycle.
- Reset in WAIT:
  - Stimulus: deassert reset mid-cycle.
  - Required: outputs 0 immediately (asynchronous); after release, a pending m_resp_valid is ignored and a fresh fetch completes normally.
